// File: rtl/sudoku_pkg.sv
// Shared types, board geometry and key codes for the sudoku board write path.
// xy2idx maps a (column,row) cursor to the linear cell index y*9+x.
package sudoku_pkg;

   localparam logic [6:0] N_CELLS  = 7'd81;
   localparam logic [3:0] GRID     = 4'd9;
   localparam logic [4:0] SCAN_LEN = 5'd27;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [4:0] KEY_NONE   = 5'h00;
   localparam logic [4:0] KEY_UP     = 5'h11;
   localparam logic [4:0] KEY_DOWN   = 5'h12;
   localparam logic [4:0] KEY_LEFT   = 5'h13;
   localparam logic [4:0] KEY_RIGHT  = 5'h14;
   localparam logic [4:0] KEY_COMMIT = 5'h1C;
   localparam logic [4:0] KEY_ERASE  = 5'h1D;
   localparam logic [4:0] KEY_CLEAR  = 5'h1F;

   // Only meaningful for in-range coordinates; callers guard x,y > 8.
   function automatic logic [6:0] xy2idx(input logic [3:0] x, input logic [3:0] y);
      return {3'b000, y} * 7'd9 + {3'b000, x};
   endfunction

endpackage

// File: rtl/sudoku_peer_addr.sv
// Maps scan step k (0..26) to the row, column and box peers of cell (x,y).
// o_is_self flags the step that lands back on the edited cell.
module sudoku_peer_addr
   import sudoku_pkg::*;
(
   input  logic [4:0] i_k,
   input  logic [3:0] i_x,
   input  logic [3:0] i_y,
   output logic [6:0] o_idx,
   output logic       o_is_self
);

   logic [3:0] w_px;
   logic [3:0] w_py;
   logic [4:0] w_j;

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_px = i_x;
      w_py = i_y;
      w_j  = '0;
      if (i_k < 5'd9) begin
         w_px = i_k[3:0];
      end else if (i_k < 5'd18) begin
         w_j  = i_k - 5'd9;
         w_py = w_j[3:0];
      end else begin
         w_j  = i_k - 5'd18;
         w_px = (i_x / 4'd3) * 4'd3 + 4'(w_j % 5'd3);
         w_py = (i_y / 4'd3) * 4'd3 + 4'(w_j / 5'd3);
      end
   end

   assign o_idx     = xy2idx(w_px, w_py);
   assign o_is_self = (w_px == i_x) && (w_py == i_y);

endmodule

// File: rtl/sudoku_cell_write_ctrl.sv
// Board store and write sequencer: commits/erases a cell, then scans its 27
// peers for a duplicate digit; also takes puzzle loads and serves the display.
module sudoku_cell_write_ctrl
   import sudoku_pkg::*;
#(
   parameter logic [4:0] P_KEY_COMMIT = KEY_COMMIT,
   parameter logic [4:0] P_KEY_ERASE  = KEY_ERASE
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] key_pulse,
   input  logic [3:0] n,
   input  logic [3:0] edit_x,
   input  logic [3:0] edit_y,
   input  logic       load_en,
   input  logic [6:0] load_idx,
   input  logic [3:0] load_val,
   input  logic [3:0] rd_x,
   input  logic [3:0] rd_y,
   output logic [3:0] rd_val,
   output logic       rd_fixed,
   output logic       rd_err,
   output logic       busy,
   output logic       conflict,
   output logic       solved,
   output logic [6:0] filled_cnt,
   output logic       reject,
   output logic       key_drop
);

   state_t      r_state, w_next;
   logic [3:0]  r_board [0:80];
   logic [80:0] r_fixed, r_err;
   logic [6:0]  r_filled, r_idx;
   logic [3:0]  r_x, r_y, r_val;
   logic [4:0]  r_k;
   logic        r_hit, r_conflict, r_solved, r_reject, r_key_drop;

   logic        w_is_commit, w_key, w_cur_oob, w_key_bad, w_load_ok, w_peer_self, w_rd_oob;
   logic [6:0]  w_cur_idx, w_peer_idx, w_rd_idx;

   assign w_is_commit = (key_pulse == P_KEY_COMMIT);
   assign w_key       = w_is_commit || (key_pulse == P_KEY_ERASE);
   assign w_cur_oob   = (edit_x >= GRID) || (edit_y >= GRID);
   assign w_cur_idx   = xy2idx(edit_x, edit_y);
   assign w_key_bad   = w_cur_oob || r_fixed[w_cur_idx] || (w_is_commit && n > GRID);
   assign w_load_ok   = (load_idx < N_CELLS);

   sudoku_peer_addr u_peer (
      .i_k       (r_k),
      .i_x       (r_x),
      .i_y       (r_y),
      .o_idx     (w_peer_idx),
      .o_is_self (w_peer_self)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (!load_en && w_key && !w_key_bad) w_next = WRITE;
         WRITE:   w_next = (r_val != 4'd0) ? CHECK : DONE;
         CHECK:   if (r_k == SCAN_LEN - 5'd1) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != IDLE);
   end

   // NOTE: the board array is reset too, because a cleared board is part of the visible reset state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 81; i++) r_board[i] <= 4'd0;
         r_fixed    <= '0;
         r_err      <= '0;
         r_filled   <= '0;
         r_idx      <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_val      <= '0;
         r_k        <= '0;
         r_hit      <= 1'b0;
         r_conflict <= 1'b0;
         r_solved   <= 1'b0;
         r_reject   <= 1'b0;
         r_key_drop <= 1'b0;
      end else begin
         r_reject   <= 1'b0;
         r_key_drop <= 1'b0;
         r_solved   <= (r_filled == N_CELLS) && (r_err == '0);
         case (r_state)
            IDLE: begin
               if (load_en) begin
                  if (w_load_ok) begin
                     r_board[load_idx] <= load_val;
                     r_fixed[load_idx] <= (load_val != 4'd0);
                     r_err[load_idx]   <= 1'b0;
                     if (r_board[load_idx] == 4'd0 && load_val != 4'd0 && r_filled != N_CELLS)
                        r_filled <= r_filled + 7'd1;
                     else if (r_board[load_idx] != 4'd0 && load_val == 4'd0)
                        r_filled <= r_filled - 7'd1;
                  end
                  if (!w_load_ok || w_key) r_key_drop <= 1'b1;
               end else if (w_key) begin
                  if (w_key_bad) begin
                     r_reject <= 1'b1;
                  end else begin
                     r_idx <= w_cur_idx;
                     r_x   <= edit_x;
                     r_y   <= edit_y;
                     r_val <= w_is_commit ? n : 4'd0;
                  end
               end
            end
            WRITE: begin
               r_board[r_idx] <= r_val;
               if (r_board[r_idx] == 4'd0 && r_val != 4'd0 && r_filled != N_CELLS)
                  r_filled <= r_filled + 7'd1;
               else if (r_board[r_idx] != 4'd0 && r_val == 4'd0)
                  r_filled <= r_filled - 7'd1;
               r_k   <= '0;
               r_hit <= 1'b0;
            end
            CHECK: begin
               r_k <= r_k + 5'd1;
               if (!w_peer_self && r_board[w_peer_idx] == r_val) r_hit <= 1'b1;
            end
            DONE: begin
               // Erase paths skip CHECK, so r_hit is still clear from WRITE.
               r_err[r_idx] <= r_hit;
               r_conflict   <= r_hit;
            end
            default: ;
         endcase
         if (r_state != IDLE && (w_key || load_en)) r_key_drop <= 1'b1;
      end
   end

   assign w_rd_oob   = (rd_x >= GRID) || (rd_y >= GRID);
   assign w_rd_idx   = xy2idx(rd_x, rd_y);
   assign rd_val     = w_rd_oob ? 4'd0 : r_board[w_rd_idx];
   assign rd_fixed   = w_rd_oob ? 1'b0 : r_fixed[w_rd_idx];
   assign rd_err     = w_rd_oob ? 1'b0 : r_err[w_rd_idx];
   assign conflict   = r_conflict;
   assign solved     = r_solved;
   assign filled_cnt = r_filled;
   assign reject     = r_reject;
   assign key_drop   = r_key_drop;

endmodule

// File: tb/tb_sudoku_cell_write_ctrl.sv
// Directed bench for sudoku_cell_write_ctrl: a vector table of key operations
// plus hand sequences for busy drops, load collisions, mid-scan reset and solve.
module tb_sudoku_cell_write_ctrl;
   import sudoku_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] key_pulse = '0;
   logic [3:0] n = '0, edit_x = '0, edit_y = '0;
   logic       load_en = 1'b0;
   logic [6:0] load_idx = '0;
   logic [3:0] load_val = '0;
   logic [3:0] rd_x = '0, rd_y = '0;
   logic [3:0] rd_val;
   logic       rd_fixed, rd_err, busy, conflict, solved, reject, key_drop;
   logic [6:0] filled_cnt;

   int checks = 0;
   int errors = 0;

   sudoku_cell_write_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_pulse  (key_pulse),
      .n          (n),
      .edit_x     (edit_x),
      .edit_y     (edit_y),
      .load_en    (load_en),
      .load_idx   (load_idx),
      .load_val   (load_val),
      .rd_x       (rd_x),
      .rd_y       (rd_y),
      .rd_val     (rd_val),
      .rd_fixed   (rd_fixed),
      .rd_err     (rd_err),
      .busy       (busy),
      .conflict   (conflict),
      .solved     (solved),
      .filled_cnt (filled_cnt),
      .reject     (reject),
      .key_drop   (key_drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] code;
      logic [3:0] x;
      logic [3:0] y;
      logic [3:0] n;
      int         exp_busy;
      logic       exp_rej;
      logic       exp_conf;
      logic       exp_err;
      logic [3:0] exp_val;
      int         exp_filled;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_cell(input logic [3:0] x, input logic [3:0] y);
      rd_x = x;
      rd_y = y;
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int cnt;
      cnt = 0;
      while (busy && cnt < 100) begin
         cnt++;
         tick();
      end
      check($sformatf("%s idle_reached", tag), int'(busy), 0);
   endtask

   task automatic apply_vec(input string tag, input vec_t v);
      int   busy_cnt;
      logic rej1, rej2, drop_seen;
      key_pulse = v.code;
      edit_x    = v.x;
      edit_y    = v.y;
      n         = v.n;
      tick();
      key_pulse = '0;
      rej1      = reject;
      drop_seen = key_drop;
      busy_cnt  = 0;
      while (busy && busy_cnt < 100) begin
         busy_cnt++;
         tick();
         drop_seen = drop_seen | key_drop;
      end
      tick();
      rej2 = reject;
      read_cell(v.x, v.y);
      check($sformatf("%s busy_cycles", tag), busy_cnt, v.exp_busy);
      check($sformatf("%s reject", tag), int'(rej1), int'(v.exp_rej));
      check($sformatf("%s reject_pulse_end", tag), int'(rej2), 0);
      check($sformatf("%s key_drop", tag), int'(drop_seen), 0);
      check($sformatf("%s conflict", tag), int'(conflict), int'(v.exp_conf));
      check($sformatf("%s rd_val", tag), int'(rd_val), int'(v.exp_val));
      check($sformatf("%s rd_err", tag), int'(rd_err), int'(v.exp_err));
      check($sformatf("%s filled_cnt", tag), int'(filled_cnt), v.exp_filled);
   endtask

   initial begin
      vec_t ev;

      //         code        x     y     n    busy rej   conf  err   val   filled
      vecs[0]  = '{KEY_COMMIT, 4'd2, 4'd3, 4'd5, 29, 1'b0, 1'b0, 1'b0, 4'd5, 2};
      vecs[1]  = '{KEY_COMMIT, 4'd4, 4'd8, 4'd7, 29, 1'b0, 1'b1, 1'b1, 4'd7, 3};
      vecs[2]  = '{KEY_COMMIT, 4'd3, 4'd1, 4'd7, 29, 1'b0, 1'b1, 1'b1, 4'd7, 4};
      vecs[3]  = '{KEY_COMMIT, 4'd4, 4'd0, 4'd9,  0, 1'b1, 1'b1, 1'b0, 4'd7, 4};
      vecs[4]  = '{KEY_ERASE,  4'd4, 4'd0, 4'd0,  0, 1'b1, 1'b1, 1'b0, 4'd7, 4};
      vecs[5]  = '{KEY_COMMIT, 4'd9, 4'd2, 4'd3,  0, 1'b1, 1'b1, 1'b0, 4'd0, 4};
      vecs[6]  = '{KEY_COMMIT, 4'd0, 4'd0, 4'd0,  2, 1'b0, 1'b0, 1'b0, 4'd0, 4};
      vecs[7]  = '{KEY_ERASE,  4'd3, 4'd1, 4'd0,  2, 1'b0, 1'b0, 1'b0, 4'd0, 3};
      vecs[8]  = '{KEY_COMMIT, 4'd2, 4'd3, 4'd6, 29, 1'b0, 1'b0, 1'b0, 4'd6, 3};
      vecs[9]  = '{KEY_COMMIT, 4'd4, 4'd8, 4'd1, 29, 1'b0, 1'b0, 1'b0, 4'd1, 3};
      vecs[10] = '{KEY_UP,     4'd1, 4'd1, 4'd4,  0, 1'b0, 1'b0, 1'b0, 4'd0, 3};

      // Reset state
      #12 rst_n = 1'b1;
      tick();
      read_cell(4'd0, 4'd0);
      check("reset busy", int'(busy), 0);
      check("reset conflict", int'(conflict), 0);
      check("reset solved", int'(solved), 0);
      check("reset filled_cnt", int'(filled_cnt), 0);
      check("reset reject", int'(reject), 0);
      check("reset key_drop", int'(key_drop), 0);
      check("reset rd_val", int'(rd_val), 0);
      check("reset rd_fixed", int'(rd_fixed), 0);

      // Clue 7 at (4,0)
      load_en = 1'b1; load_idx = 7'd4; load_val = 4'd7;
      tick();
      load_en = 1'b0;
      read_cell(4'd4, 4'd0);
      check("load busy", int'(busy), 0);
      check("load rd_val", int'(rd_val), 7);
      check("load rd_fixed", int'(rd_fixed), 1);
      check("load filled_cnt", int'(filled_cnt), 1);

      for (int i = 0; i < 11; i++) apply_vec($sformatf("v%0d", i), vecs[i]);

      // Second commit arriving mid-scan is dropped
      key_pulse = KEY_COMMIT; edit_x = 4'd7; edit_y = 4'd7; n = 4'd2;
      tick();
      key_pulse = '0;
      for (int i = 0; i < 4; i++) tick();
      key_pulse = KEY_COMMIT; edit_x = 4'd6; edit_y = 4'd6; n = 4'd8;
      tick();
      key_pulse = '0;
      check("drop key_drop", int'(key_drop), 1);
      tick();
      check("drop pulse_end", int'(key_drop), 0);
      wait_idle("drop");
      read_cell(4'd6, 4'd6);
      check("drop rd_val(6,6)", int'(rd_val), 0);
      read_cell(4'd7, 4'd7);
      check("drop rd_val(7,7)", int'(rd_val), 2);
      check("drop filled_cnt", int'(filled_cnt), 4);

      // Load and commit collide in IDLE: load wins
      load_en = 1'b1; load_idx = 7'd80; load_val = 4'd3;
      key_pulse = KEY_COMMIT; edit_x = 4'd0; edit_y = 4'd0; n = 4'd4;
      tick();
      load_en = 1'b0; key_pulse = '0;
      check("collide key_drop", int'(key_drop), 1);
      check("collide busy", int'(busy), 0);
      tick();
      check("collide busy_after", int'(busy), 0);
      read_cell(4'd8, 4'd8);
      check("collide rd_val(8,8)", int'(rd_val), 3);
      check("collide rd_fixed(8,8)", int'(rd_fixed), 1);
      read_cell(4'd0, 4'd0);
      check("collide rd_val(0,0)", int'(rd_val), 0);
      check("collide filled_cnt", int'(filled_cnt), 5);

      // Out-of-range load index
      load_en = 1'b1; load_idx = 7'd81; load_val = 4'd2;
      tick();
      load_en = 1'b0;
      check("badload key_drop", int'(key_drop), 1);
      check("badload filled_cnt", int'(filled_cnt), 5);

      ev = '{KEY_ERASE, 4'd2, 4'd3, 4'd0, 2, 1'b0, 1'b0, 1'b0, 4'd0, 4};
      apply_vec("erase23", ev);

      // Reset while the scan is at k=10
      key_pulse = KEY_COMMIT; edit_x = 4'd0; edit_y = 4'd8; n = 4'd5;
      tick();
      key_pulse = '0;
      for (int i = 0; i < 11; i++) tick();
      check("midrst busy_before", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("midrst busy", int'(busy), 0);
      check("midrst filled_cnt", int'(filled_cnt), 0);
      check("midrst conflict", int'(conflict), 0);
      read_cell(4'd0, 4'd8);
      check("midrst rd_val(0,8)", int'(rd_val), 0);
      read_cell(4'd7, 4'd7);
      check("midrst rd_val(7,7)", int'(rd_val), 0);
      read_cell(4'd8, 4'd8);
      check("midrst rd_fixed(8,8)", int'(rd_fixed), 0);
      rst_n = 1'b1;
      tick();
      ev = '{KEY_COMMIT, 4'd1, 4'd1, 4'd3, 29, 1'b0, 1'b0, 1'b0, 4'd3, 1};
      apply_vec("postrst", ev);

      // 80-clue valid grid, then the final digit completes it
      for (int y = 0; y < 9; y++) begin
         for (int x = 0; x < 9; x++) begin
            if (!(x == 8 && y == 8)) begin
               load_en  = 1'b1;
               load_idx = 7'(y * 9 + x);
               load_val = 4'(((y * 3 + y / 3 + x) % 9) + 1);
               tick();
            end
         end
      end
      load_en = 1'b0;
      tick();
      check("grid filled_cnt", int'(filled_cnt), 80);
      check("grid solved", int'(solved), 0);
      key_pulse = KEY_COMMIT; edit_x = 4'd8; edit_y = 4'd8; n = 4'd8;
      tick();
      key_pulse = '0;
      check("solve busy", int'(busy), 1);
      tick();
      check("solve filled_cnt", int'(filled_cnt), 81);
      check("solve solved_lag", int'(solved), 0);
      tick();
      check("solve solved_next", int'(solved), 1);
      wait_idle("solve");
      read_cell(4'd8, 4'd8);
      check("solve conflict", int'(conflict), 0);
      check("solve rd_err(8,8)", int'(rd_err), 0);
      check("solve rd_val(8,8)", int'(rd_val), 8);
      check("solve solved_held", int'(solved), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
